punc_control_fsm: RTL and testbench



---
 rtl/punc_control_fsm_if.sv | 59 +++++
 rtl/punc_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_punc_control_fsm.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_control_fsm_if.sv
// Control bundle between the PUnC sequencer (master) and the PUnC datapath (slave).
// PUNC_ILLEGAL_TRAP_EN adds the sticky illegal_op flag to the bundle.
interface punc_control_fsm_if;
    logic [15:0] ir;
    logic        flag_n;
    logic        flag_z;
    logic        flag_p;
    logic        pc_ld;
    logic        pc_inc;
    logic        pc_clr;
    logic        pc_data_sel;
    logic        pc_add_sel;
    logic        ir_ld;
    logic [1:0]  addr_mem_sel;
    logic        w_en_mem;
    logic        store_ld;
    logic [2:0]  r_addr_0_rf;
    logic [2:0]  r_addr_1_rf;
    logic [2:0]  w_addr_rf;
    logic [1:0]  w_rf_sel;
    logic        w_en_rf;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  sext_sel;
    logic [1:0]  alu_sel;
    logic        nzp_sel;
    logic        nzp_ld;
    logic        halted;
    logic [2:0]  state_dbg;
`ifdef PUNC_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    modport master (
        input  ir, flag_n, flag_z, flag_p,
        output
`ifdef PUNC_ILLEGAL_TRAP_EN
               illegal_op,
`endif
               pc_ld, pc_inc, pc_clr, pc_data_sel, pc_add_sel, ir_ld,
               addr_mem_sel, w_en_mem, store_ld,
               r_addr_0_rf, r_addr_1_rf, w_addr_rf, w_rf_sel, w_en_rf,
               a_sel, b_sel, sext_sel, alu_sel, nzp_sel, nzp_ld,
               halted, state_dbg
    );

    modport slave (
        output ir, flag_n, flag_z, flag_p,
        input
`ifdef PUNC_ILLEGAL_TRAP_EN
               illegal_op,
`endif
               pc_ld, pc_inc, pc_clr, pc_data_sel, pc_add_sel, ir_ld,
               addr_mem_sel, w_en_mem, store_ld,
               r_addr_0_rf, r_addr_1_rf, w_addr_rf, w_rf_sel, w_en_rf,
               a_sel, b_sel, sext_sel, alu_sel, nzp_sel, nzp_ld,
               halted, state_dbg
    );
endinterface

// File: rtl/punc_control_fsm.sv
// PUnC LC3 fetch/decode/execute sequencer; datapath controls decode combinationally from state and ir.
// Optional macro PUNC_ILLEGAL_TRAP_EN: opcodes 1000/1101 halt and raise sticky illegal_op.
module punc_control_fsm #(
    parameter int OPC_W = 4
) (
    input logic               clk,
    input logic               rst,
    punc_control_fsm_if.master ctl
);
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_RSV8 = 4'b1000;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_RSVD = 4'b1101;
    localparam logic [OPC_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPC_W-1:0] OP_TRAP = 4'b1111;

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc;
    logic [2:0]       dst, base;
    logic             illegal_hit;
    logic             unused_ir;

    assign opc       = ctl.ir[15:12];
    assign dst       = ctl.ir[11:9];
    assign base      = ctl.ir[8:6];
    assign unused_ir = ^ctl.ir[4:3];

`ifdef PUNC_ILLEGAL_TRAP_EN
    assign illegal_hit = (opc == OP_RSV8) || (opc == OP_RSVD);
`else
    assign illegal_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = ((opc == OP_TRAP) || illegal_hit) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = ((opc == OP_LDI) || (opc == OP_STI)) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

`ifdef PUNC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d      = illegal_q | ((state_q == S_DECODE) && illegal_hit);
    assign ctl.illegal_op = illegal_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INIT;
`ifdef PUNC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef PUNC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign ctl.state_dbg = state_q;
    assign ctl.halted    = (state_q == S_HALT);

    always_comb begin
        ctl.pc_ld        = 1'b0;
        ctl.pc_inc       = 1'b0;
        ctl.pc_clr       = 1'b0;
        ctl.pc_data_sel  = 1'b0;
        ctl.pc_add_sel   = 1'b0;
        ctl.ir_ld        = 1'b0;
        ctl.addr_mem_sel = 2'd0;
        ctl.w_en_mem     = 1'b0;
        ctl.store_ld     = 1'b0;
        ctl.r_addr_0_rf  = 3'd0;
        ctl.r_addr_1_rf  = 3'd0;
        ctl.w_addr_rf    = 3'd0;
        ctl.w_rf_sel     = 2'd0;
        ctl.w_en_rf      = 1'b0;
        ctl.a_sel        = 1'b0;
        ctl.b_sel        = 1'b0;
        ctl.sext_sel     = 2'd0;
        ctl.alu_sel      = 2'd0;
        ctl.nzp_sel      = 1'b0;
        ctl.nzp_ld       = 1'b0;
        case (state_q)
            S_INIT: ctl.pc_clr = 1'b1;
            S_FETCH: begin
                ctl.ir_ld  = 1'b1;
                ctl.pc_inc = 1'b1;
            end
            S_EXEC: begin
                case (opc)
                    OP_ADD, OP_AND, OP_NOT: begin
                        ctl.w_addr_rf   = dst;
                        ctl.r_addr_0_rf = base;
                        ctl.r_addr_1_rf = ctl.ir[2:0];
                        ctl.a_sel       = 1'b1;
                        ctl.b_sel       = ctl.ir[5];
                        ctl.w_rf_sel    = 2'd2;
                        ctl.w_en_rf     = 1'b1;
                        ctl.nzp_ld      = 1'b1;
                        ctl.alu_sel     = (opc == OP_AND) ? 2'd1 : (opc == OP_NOT) ? 2'd3 : 2'd0;
                    end
                    OP_BR: begin
                        ctl.pc_ld      = (ctl.ir[11] & ctl.flag_n) | (ctl.ir[10] & ctl.flag_z)
                                       | (ctl.ir[9] & ctl.flag_p);
                        ctl.pc_add_sel = 1'b1;
                    end
                    OP_JMP: begin
                        ctl.r_addr_0_rf = base;
                        ctl.pc_data_sel = 1'b1;
                        ctl.pc_ld       = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 is read (JSRR base) and written on the same edge; the RF returns the old value.
                        ctl.w_addr_rf = 3'd7;
                        ctl.w_en_rf   = 1'b1;
                        ctl.pc_ld     = 1'b1;
                        if (!ctl.ir[11]) begin
                            ctl.r_addr_0_rf = base;
                            ctl.pc_data_sel = 1'b1;
                        end
                    end
                    OP_LD, OP_LDR, OP_LEA, OP_ST, OP_STR, OP_LDI, OP_STI: begin
                        ctl.b_sel = 1'b1;
                        if ((opc == OP_LDR) || (opc == OP_STR)) begin
                            ctl.a_sel       = 1'b1;
                            ctl.r_addr_0_rf = base;
                            ctl.sext_sel    = 2'd1;
                        end else begin
                            ctl.sext_sel    = 2'd2;
                        end
                        if ((opc == OP_LD) || (opc == OP_LDR)) begin
                            ctl.addr_mem_sel = 2'd1;
                            ctl.w_addr_rf    = dst;
                            ctl.w_rf_sel     = 2'd1;
                            ctl.w_en_rf      = 1'b1;
                            ctl.nzp_sel      = 1'b1;
                            ctl.nzp_ld       = 1'b1;
                        end else if (opc == OP_LEA) begin
                            ctl.w_addr_rf    = dst;
                            ctl.w_rf_sel     = 2'd2;
                            ctl.w_en_rf      = 1'b1;
                            ctl.nzp_ld       = 1'b1;
                        end else if ((opc == OP_ST) || (opc == OP_STR)) begin
                            ctl.addr_mem_sel = 2'd1;
                            ctl.r_addr_1_rf  = dst;
                            ctl.w_en_mem     = 1'b1;
                        end else begin
                            ctl.addr_mem_sel = 2'd1;
                            ctl.store_ld     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                // Second access goes to the pointer captured in the store register.
                ctl.addr_mem_sel = 2'd2;
                if (opc == OP_LDI) begin
                    ctl.w_addr_rf = dst;
                    ctl.w_rf_sel  = 2'd1;
                    ctl.w_en_rf   = 1'b1;
                    ctl.nzp_sel   = 1'b1;
                    ctl.nzp_ld    = 1'b1;
                end else begin
                    ctl.r_addr_1_rf = dst;
                    ctl.w_en_mem    = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_punc_control_fsm.sv
// Bench for punc_control_fsm: directed vector table, corner sequences and random instructions vs an ISA-level model.
module tb_punc_control_fsm;
  typedef struct packed {
    logic [2:0] state;
    logic       halted;
    logic       pc_ld, pc_inc, pc_clr, pc_data_sel, pc_add_sel, ir_ld;
    logic [1:0] addr_mem_sel;
    logic       w_en_mem, store_ld;
    logic [2:0] r0, r1, wa;
    logic [1:0] w_rf_sel;
    logic       w_en_rf, a_sel, b_sel;
    logic [1:0] sext_sel, alu_sel;
    logic       nzp_sel, nzp_ld;
  } ctl_t;
  localparam int W = $bits(ctl_t);

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          n_cyc;
    logic [2:0]  eff;   // {any w_en_rf, any w_en_mem, any pc_ld} over the instruction
  } vec_t;

  localparam logic [2:0] PH_INIT = 3'd0, PH_FETCH = 3'd1, PH_DECODE = 3'd2,
                         PH_EXEC = 3'd3, PH_EXEC2 = 3'd4, PH_HALT = 3'd5;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_q[$];

  punc_control_fsm_if bus();
  punc_control_fsm dut (.clk(clk), .rst(rst), .ctl(bus));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit halts_after_decode(input logic [3:0] op);
`ifdef PUNC_ILLEGAL_TRAP_EN
    return (op == 4'hF) || (op == 4'h8) || (op == 4'hD);
`else
    return (op == 4'hF);
`endif
  endfunction

  function automatic ctl_t model(input logic [2:0] ph, input logic [15:0] ir, input logic [2:0] nzp);
    ctl_t c;
    logic [3:0] op;
    bit mem_addr, base_form;
    c = '0;
    c.state = ph;
    op = ir[15:12];
    mem_addr  = op inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hE};
    base_form = op inside {4'h6, 4'h7};
    if (ph == PH_INIT) c.pc_clr = 1'b1;
    else if (ph == PH_FETCH) begin c.ir_ld = 1'b1; c.pc_inc = 1'b1; end
    else if (ph == PH_HALT) c.halted = 1'b1;
    else if (ph == PH_EXEC) begin
      if (op inside {4'h1, 4'h5, 4'h9}) begin
        c.wa = ir[11:9]; c.r0 = ir[8:6]; c.r1 = ir[2:0];
        c.a_sel = 1'b1; c.b_sel = ir[5];
        c.w_rf_sel = 2'd2; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1;
        c.alu_sel = (op == 4'h5) ? 2'd1 : ((op == 4'h9) ? 2'd3 : 2'd0);
      end else if (op == 4'h0) begin
        c.pc_add_sel = 1'b1;
        c.pc_ld = |(ir[11:9] & nzp);
      end else if (op == 4'hC) begin
        c.r0 = ir[8:6]; c.pc_data_sel = 1'b1; c.pc_ld = 1'b1;
      end else if (op == 4'h4) begin
        c.wa = 3'd7; c.w_en_rf = 1'b1; c.pc_ld = 1'b1;
        if (!ir[11]) begin c.r0 = ir[8:6]; c.pc_data_sel = 1'b1; end
      end else if (mem_addr) begin
        c.b_sel = 1'b1;
        if (base_form) begin c.a_sel = 1'b1; c.r0 = ir[8:6]; c.sext_sel = 2'd1; end
        else c.sext_sel = 2'd2;
        case (op)
          4'h2, 4'h6: begin
            c.addr_mem_sel = 2'd1; c.wa = ir[11:9]; c.w_rf_sel = 2'd1;
            c.w_en_rf = 1'b1; c.nzp_sel = 1'b1; c.nzp_ld = 1'b1;
          end
          4'hE: begin c.wa = ir[11:9]; c.w_rf_sel = 2'd2; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1; end
          4'h3, 4'h7: begin c.addr_mem_sel = 2'd1; c.r1 = ir[11:9]; c.w_en_mem = 1'b1; end
          default: begin c.addr_mem_sel = 2'd1; c.store_ld = 1'b1; end
        endcase
      end
    end else if (ph == PH_EXEC2) begin
      c.addr_mem_sel = 2'd2;
      if (op == 4'hA) begin
        c.wa = ir[11:9]; c.w_rf_sel = 2'd1; c.w_en_rf = 1'b1; c.nzp_sel = 1'b1; c.nzp_ld = 1'b1;
      end else begin
        c.r1 = ir[11:9]; c.w_en_mem = 1'b1;
      end
    end
    return c;
  endfunction

  // Expected per-cycle controls for one instruction, FETCH through its last execute cycle.
  task automatic push_instr(input logic [15:0] ir, input logic [2:0] nzp);
    logic [3:0] op;
    op = ir[15:12];
    exp_q.push_back(model(PH_FETCH, ir, nzp));
    exp_q.push_back(model(PH_DECODE, ir, nzp));
    if (!halts_after_decode(op)) begin
      exp_q.push_back(model(PH_EXEC, ir, nzp));
      if (op == 4'hA || op == 4'hB) exp_q.push_back(model(PH_EXEC2, ir, nzp));
    end
  endtask

  // ---------------- driver / monitor ----------------
  function automatic ctl_t sample();
    ctl_t c;
    c.state = bus.state_dbg;           c.halted = bus.halted;
    c.pc_ld = bus.pc_ld;               c.pc_inc = bus.pc_inc;
    c.pc_clr = bus.pc_clr;             c.pc_data_sel = bus.pc_data_sel;
    c.pc_add_sel = bus.pc_add_sel;     c.ir_ld = bus.ir_ld;
    c.addr_mem_sel = bus.addr_mem_sel; c.w_en_mem = bus.w_en_mem;
    c.store_ld = bus.store_ld;         c.r0 = bus.r_addr_0_rf;
    c.r1 = bus.r_addr_1_rf;            c.wa = bus.w_addr_rf;
    c.w_rf_sel = bus.w_rf_sel;         c.w_en_rf = bus.w_en_rf;
    c.a_sel = bus.a_sel;               c.b_sel = bus.b_sel;
    c.sext_sel = bus.sext_sel;         c.alu_sel = bus.alu_sel;
    c.nzp_sel = bus.nzp_sel;           c.nzp_ld = bus.nzp_ld;
    return c;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ir, input logic [2:0] nzp);
    bus.ir = ir;
    {bus.flag_n, bus.flag_z, bus.flag_p} = nzp;
  endtask

  // Called #1 after the edge that enters FETCH; returns #1 after the edge that leaves the instruction.
  task automatic run_instr(input string name, input logic [15:0] ir, input logic [2:0] nzp,
                           output int cyc, output logic [2:0] eff);
    ctl_t act;
    int n;
    drive(ir, nzp);
    push_instr(ir, nzp);
    n = exp_q.size();
    cyc = 0;
    eff = 3'b000;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      act = sample();
      check(name, act, exp_q.pop_front());
      eff |= {act.w_en_rf, act.w_en_mem, act.pc_ld};
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset_and_release(input string name);
    rst = 1'b0;
    #1;
    check({name, "_async"}, sample(), model(PH_INIT, bus.ir, 3'b000));
`ifdef PUNC_ILLEGAL_TRAP_EN
    check_int({name, "_illegal_clr"}, {31'd0, bus.illegal_op}, 32'd0);
`endif
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[$];

  initial begin
    int cyc;
    logic [2:0] eff;
    logic [15:0] rir;
    logic [2:0] rnzp;

    vecs.push_back('{"add_r1_r2_r3", 16'h1283, 3'b000, 3, 3'b100});
    vecs.push_back('{"and_imm",      16'h5262, 3'b010, 3, 3'b100});
    vecs.push_back('{"not",          16'h927F, 3'b100, 3, 3'b100});
    vecs.push_back('{"brz_taken",    16'h0405, 3'b010, 3, 3'b001});
    vecs.push_back('{"brz_not",      16'h0405, 3'b001, 3, 3'b000});
    vecs.push_back('{"brnzp_n",      16'h0E02, 3'b100, 3, 3'b001});
    vecs.push_back('{"br_nop",       16'h0000, 3'b111, 3, 3'b000});
    vecs.push_back('{"jmp_r7",       16'hC1C0, 3'b000, 3, 3'b001});
    vecs.push_back('{"jsr",          16'h4805, 3'b000, 3, 3'b101});
    vecs.push_back('{"jsrr_r2",      16'h4080, 3'b000, 3, 3'b101});
    vecs.push_back('{"ld",           16'h2205, 3'b000, 3, 3'b100});
    vecs.push_back('{"ldr",          16'h6283, 3'b000, 3, 3'b100});
    vecs.push_back('{"lea",          16'hE205, 3'b000, 3, 3'b100});
    vecs.push_back('{"st",           16'h3205, 3'b000, 3, 3'b010});
    vecs.push_back('{"str",          16'h7283, 3'b000, 3, 3'b010});
    vecs.push_back('{"ldi_r1",       16'hA203, 3'b000, 4, 3'b100});
    vecs.push_back('{"sti_r1",       16'hB203, 3'b000, 4, 3'b010});
`ifndef PUNC_ILLEGAL_TRAP_EN
    vecs.push_back('{"nop_8",        16'h8000, 3'b111, 3, 3'b000});
`endif

    rst = 1'b0;
    drive(16'h0000, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_init", sample(), model(PH_INIT, 16'h0000, 3'b000));
`ifdef PUNC_ILLEGAL_TRAP_EN
    check_int("reset_illegal", {31'd0, bus.illegal_op}, 32'd0);
`endif
    #1 rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].ir, vecs[i].nzp, cyc, eff);
      check_int({vecs[i].name, "_cycles"}, cyc, vecs[i].n_cyc);
      check_int({vecs[i].name, "_effects"}, {29'd0, eff}, {29'd0, vecs[i].eff});
      check_int({vecs[i].name, "_refetch"}, {29'd0, bus.state_dbg}, {29'd0, PH_FETCH});
    end

    // Reset in the middle of a store: the write enable must drop without a clock edge.
    drive(16'h3205, 3'b000);
    @(negedge clk); check("st_abort_fetch", sample(), model(PH_FETCH, 16'h3205, 3'b000));
    @(posedge clk); #1;
    @(negedge clk); check("st_abort_decode", sample(), model(PH_DECODE, 16'h3205, 3'b000));
    @(posedge clk); #2;
    check_int("st_abort_wen_before", {31'd0, bus.w_en_mem}, 32'd1);
    apply_reset_and_release("st_abort");
    check_int("st_abort_wen_after", {31'd0, bus.w_en_mem}, 32'd0);

    // Reserved opcode: NOP by default, terminal trap when the illegal-op feature is built in.
`ifdef PUNC_ILLEGAL_TRAP_EN
    run_instr("rsvd_d", 16'hD000, 3'b000, cyc, eff);
    @(negedge clk);
    check("rsvd_d_halt", sample(), model(PH_HALT, 16'hD000, 3'b000));
    check_int("rsvd_d_illegal", {31'd0, bus.illegal_op}, 32'd1);
    @(posedge clk); #1;
    apply_reset_and_release("rsvd_d_reset");
`else
    run_instr("rsvd_d", 16'hD000, 3'b111, cyc, eff);
    check_int("rsvd_d_cycles", cyc, 3);
    check_int("rsvd_d_refetch", {29'd0, bus.state_dbg}, {29'd0, PH_FETCH});
`endif

    for (int i = 0; i < 60; i++) begin
      do rir = 16'($urandom); while (halts_after_decode(rir[15:12]));
      rnzp = 3'($urandom_range(0, 7));
      run_instr($sformatf("rand_%0d_%h_%b", i, rir, rnzp), rir, rnzp, cyc, eff);
    end

    // TRAP: absorbing HALT with every enable low, left only through reset.
    run_instr("trap", 16'hF025, 3'b111, cyc, eff);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt_cyc_%0d", k), sample(), model(PH_HALT, 16'hF025, 3'b111));
      @(posedge clk); #1;
    end
    #2;
    apply_reset_and_release("halt_reset");
    check_int("halt_reset_halted", {31'd0, bus.halted}, 32'd0);

    run_instr("post_reset_add", 16'h1283, 3'b000, cyc, eff);
    check_int("post_reset_cycles", cyc, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
